// File: rtl/bcd_digit_feeder.sv
// bcd_digit_feeder: converts an 8-bit binary value to BCD and feeds its digits,
// most significant first, to a 7-segment decoder through its WAIT handshake.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   i_start      convert request, sampled only while idle
//   i_bin_in     8-bit unsigned value captured on an accepted start
//   i_dec_wait   decoder WAIT handshake input
//   o_digit_out  BCD digit to the decoder (bits 7:4 always 0)
//   o_dec_en     decoder enable
//   o_dec_rst    decoder restart pulse
//   o_digit_sel  current digit position (2 hundreds, 1 tens, 0 ones)
//   o_digit_done strobe: decoder output valid for o_digit_sel
//   o_busy       high whenever not idle
//   o_done       strobe after the last digit
//   o_err        strobe on handshake timeout
//
// Build option: define BCD_FEED_SKIP_ZEROS_EN to suppress leading-zero digits.
module bcd_digit_feeder (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_start,
    input  logic [7:0] i_bin_in,
    input  logic       i_dec_wait,
    output logic [7:0] o_digit_out,
    output logic       o_dec_en,
    output logic       o_dec_rst,
    output logic [1:0] o_digit_sel,
    output logic       o_digit_done,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);
    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, WAIT_HI, WAIT_LO, NEXT, FIN} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd, w_adj, w_shift;
    logic [2:0]  r_cnt;
    logic [1:0]  r_idx, w_start_idx;
    logic [3:0]  r_wd;
    logic        w_wd_exp, w_show, w_in_wait;
    // double-dabble step: correct nibbles >= 5, then shift in the next MSB
    assign w_adj[3:0]   = (r_bcd[3:0]  > 4'd4) ? r_bcd[3:0]  + 4'd3 : r_bcd[3:0];
    assign w_adj[7:4]   = (r_bcd[7:4]  > 4'd4) ? r_bcd[7:4]  + 4'd3 : r_bcd[7:4];
    assign w_adj[11:8]  = (r_bcd[11:8] > 4'd4) ? r_bcd[11:8] + 4'd3 : r_bcd[11:8];
    assign w_shift      = {w_adj[10:0], r_bin[7]};
`ifdef BCD_FEED_SKIP_ZEROS_EN
    // start at the highest nonzero digit of the finished result; ones always sent
    assign w_start_idx  = (w_shift[11:8] != 4'd0) ? 2'd2 : (w_shift[7:4] != 4'd0) ? 2'd1 : 2'd0;
`else
    assign w_start_idx  = 2'd2;
`endif
    assign w_wd_exp     = r_wd == 4'd15;
    assign w_in_wait    = r_state == WAIT_HI || r_state == WAIT_LO;
    assign w_show       = r_state == LOAD || w_in_wait || r_state == NEXT;
    assign o_digit_out  = w_show ? {4'd0, r_bcd[{r_idx, 2'b00} +: 4]} : 8'd0;
    assign o_digit_sel  = w_show ? r_idx : 2'd0;
    assign o_busy       = r_state != IDLE;
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next       = r_state;
        o_dec_en     = 1'b0;
        o_dec_rst    = 1'b0;
        o_digit_done = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            IDLE:    w_next = i_start ? CONVERT : IDLE;
            CONVERT: w_next = (r_cnt == 3'd7) ? LOAD : CONVERT;
            LOAD: begin
                o_dec_en  = 1'b1;
                o_dec_rst = 1'b1;
                w_next    = WAIT_HI;
            end
            WAIT_HI, WAIT_LO: begin
                o_err    = w_wd_exp;
                o_dec_en = !w_wd_exp;
                w_next   = w_wd_exp ? IDLE :
                           (r_state == WAIT_HI) ? (i_dec_wait ? WAIT_LO : WAIT_HI) :
                           (i_dec_wait ? WAIT_LO : NEXT);
            end
            NEXT: begin
                o_digit_done = 1'b1;
                w_next       = (r_idx == 2'd0) ? FIN : LOAD;
            end
            FIN: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bin <= 8'd0;
            r_bcd <= 12'd0;
            r_cnt <= 3'd0;
            r_idx <= 2'd0;
            r_wd  <= 4'd0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_bin <= i_bin_in;
                r_bcd <= 12'd0;
                r_cnt <= 3'd0;
            end
            if (r_state == CONVERT) begin
                r_bcd <= w_shift;
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + 3'd1;
                r_idx <= w_start_idx;
            end
            if (r_state == NEXT && r_idx != 2'd0) r_idx <= r_idx - 2'd1;
            // cleared on entry to either wait state, counts while waiting
            r_wd <= (w_in_wait && !(r_state == WAIT_HI && i_dec_wait)) ? r_wd + 4'd1 : 4'd0;
        end
    end
endmodule

// File: tb/tb_bcd_digit_feeder.sv
// tb_bcd_digit_feeder: directed scoreboard bench for bcd_digit_feeder.
module tb_bcd_digit_feeder;
    logic       CLK = 1'b0, RST = 1'b1, start = 1'b0, tie0 = 1'b0;
    logic [7:0] bin = 8'd0;
    logic       dec_wait;
    logic [7:0] o_digit_out;
    logic       o_dec_en, o_dec_rst, o_digit_done, o_busy, o_done, o_err;
    logic [1:0] o_digit_sel;
    logic [15:0] outs;
    int tests = 0, fails = 0;
    int dc = 0, cyc = 0, n_done = 0, n_err = 0, busy_cnt = 0, err_cyc = 0, rst_cyc = 0;
    int obs_q[$], obs_cyc[$], exp_q[$];
    always #5 CLK = ~CLK;
    bcd_digit_feeder dut (
        .CLK(CLK), .RST(RST), .i_start(start), .i_bin_in(bin), .i_dec_wait(dec_wait),
        .o_digit_out(o_digit_out), .o_dec_en(o_dec_en), .o_dec_rst(o_dec_rst),
        .o_digit_sel(o_digit_sel), .o_digit_done(o_digit_done), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );
    assign outs = {o_digit_out, o_dec_en, o_dec_rst, o_digit_sel, o_digit_done, o_busy, o_done, o_err};
    // decoder model: WAIT rises 2 cycles after the restart pulse and stays high 2 cycles
    always @(posedge CLK) dc <= RST ? 0 : o_dec_rst ? 1 : (dc == 0 || dc == 4) ? 0 : dc + 1;
    assign dec_wait = !tie0 && (dc == 2 || dc == 3);
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (o_digit_done) begin
            obs_q.push_back(int'(o_digit_sel) * 256 + int'(o_digit_out));
            obs_cyc.push_back(cyc);
        end
        if (o_done) n_done++;
        if (o_err) begin n_err++; err_cyc = cyc; end
        if (o_dec_rst) rst_cyc = cyc;
        if (o_busy) busy_cnt++;
    end
    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic expect_digits(input logic [7:0] v, output int n);
        int d[3];
        int s;
        d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = v / 100;
        s = 2;
`ifdef BCD_FEED_SKIP_ZEROS_EN
        s = (d[2] != 0) ? 2 : (d[1] != 0) ? 1 : 0;
`endif
        for (int i = s; i >= 0; i--) exp_q.push_back(i * 256 + d[i]);
        n = s + 1;
    endtask
    task automatic compare_obs(input int k0);
        int e;
        for (int k = k0; k < obs_q.size(); k++) begin
            if (exp_q.size() == 0) chk("extra_digit", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("digit_sel", obs_q[k] / 256, e / 256);
                chk("digit_val", obs_q[k] % 256, e % 256);
            end
            if (k > k0) chk("digit_gap", obs_cyc[k] - obs_cyc[k-1], 6);
        end
        chk("missing_digits", exp_q.size(), 0);
        exp_q.delete();
    endtask
    task automatic run(input logic [7:0] v, input bit repulse);
        int n, d0, e0, b0, k0, i;
        d0 = n_done; e0 = n_err; b0 = busy_cnt; k0 = obs_q.size();
        expect_digits(v, n);
        start = 1'b1; bin = v;
        @(negedge CLK);
        for (i = 0; i < 300 && n_done == d0 && n_err == e0; i++) begin
            if (repulse && (i == 4 || i == 20)) begin start = 1'b1; bin = v ^ 8'h5A; end
            else start = 1'b0;
            @(negedge CLK);
        end
        start = 1'b0;
        chk("run_timeout", int'(i < 300), 1);
        @(negedge CLK);
        compare_obs(k0);
        chk("done_count", n_done - d0, 1);
        chk("err_count", n_err - e0, 0);
        chk("busy_cycles", busy_cnt - b0, 9 + 6 * n);
    endtask
    initial begin
        int d0, e0, k0, i;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", int'(outs), 0);
        RST = 1'b0;
        run(8'd157, 1'b0);
        run(8'd255, 1'b0);
        run(8'd0, 1'b0);
        run(8'd7, 1'b0);
        run(8'd105, 1'b0);
        tie0 = 1'b1;
        d0 = n_done; e0 = n_err; k0 = obs_q.size();
        start = 1'b1; bin = 8'd200;
        @(negedge CLK);
        start = 1'b0;
        for (i = 0; i < 100 && n_err == e0; i++) @(negedge CLK);
        chk("wd_timeout", int'(i < 100), 1);
        chk("wd_err_gap", err_cyc - rst_cyc, 16);
        @(negedge CLK);
        chk("wd_err_count", n_err - e0, 1);
        chk("wd_no_done", n_done - d0, 0);
        chk("wd_no_digits", obs_q.size() - k0, 0);
        chk("wd_idle", int'(o_busy), 0);
        tie0 = 1'b0;
        run(8'd99, 1'b0);
        d0 = n_done; k0 = obs_q.size();
        exp_q.push_back(2 * 256 + 1);
        start = 1'b1; bin = 8'd123;
        @(negedge CLK);
        start = 1'b0;
        for (i = 0; i < 100 && obs_q.size() == k0; i++) @(negedge CLK);
        chk("rst_first_digit_timeout", int'(i < 100), 1);
        repeat (4) @(negedge CLK);
        chk("rst_in_wait_lo", int'({o_dec_en, dec_wait, o_digit_sel}), 'b1101);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_outputs", int'(outs), 0);
        compare_obs(k0);
        chk("rst_no_done", n_done - d0, 0);
        RST = 1'b0;
        run(8'd42, 1'b0);
        run(8'd157, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bcd_digit_feeder.md
BCD_DIGIT_FEEDER -- requirements
Module: bcd_digit_feeder

Interface
REQ-001 The block SHALL have reset RST, synchronous, active-high; clock CLK.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RST  in  1  synchronous active-high reset; wins over every other input.
REQ-004 START  in  1  request to convert BIN_IN; sampled only in IDLE.
REQ-005 BIN_IN  in  8  unsigned binary value, 0..255.
REQ-006 DEC_WAIT  in  1  WAIT output of the downstream 7-segment decoder.
REQ-007 DIGIT_OUT  out  8  BCD digit to the decoder's DATA_IN; bits 7:4 always 0.
REQ-008 DEC_EN  out  1  decoder enable.
REQ-009 DEC_RST  out  1  decoder restart pulse.
REQ-010 DIGIT_SEL  out  2  position of the current digit: 2 = hundreds, 1 = tens, 0 = ones.
REQ-011 DIGIT_DONE  out  1  one-cycle strobe; decoder segment output is valid for DIGIT_SEL.
REQ-012 BUSY  out  1  high whenever state is not IDLE.
REQ-013 DONE  out  1  one-cycle strobe when all digits have been sent.
REQ-014 ERR  out  1  one-cycle strobe on a handshake timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, CONVERT, LOAD, WAIT_HI, WAIT_LO, NEXT and FIN.
REQ-016 IDLE with START=1: capture BIN_IN, clear the 12-bit BCD register, clear the shift counter, go to CONVERT.
REQ-017 CONVERT: 8 cycles of double-dabble, one bit per cycle: add 3 to each nibble that is 5 or more, then shift left with the next BIN_IN bit (MSB first); after the 8th cycle go to LOAD with the start index.
REQ-018 LOAD, 1 cycle: DEC_EN=1, DEC_RST=1, DIGIT_OUT = BCD nibble[index]; go to WAIT_HI.
REQ-019 WAIT_HI: DEC_EN=1, DEC_RST=0; on DEC_WAIT=1 go to WAIT_LO.
REQ-020 WAIT_LO: DEC_EN=1; on DEC_WAIT=0 go to NEXT.
REQ-021 DIGIT_OUT and DIGIT_SEL SHALL stay stable from LOAD through NEXT.
REQ-022 NEXT, 1 cycle: DIGIT_DONE=1, DEC_EN=0; if index=0 go to FIN, else decrement index and go to LOAD.
REQ-023 FIN, 1 cycle: DONE=1; go to IDLE.
REQ-024 With a conforming decoder, each digit SHALL take exactly 6 cycles (LOAD to end of NEXT), so a 3-digit conversion keeps BUSY high for 8 + 18 + 1 = 27 cycles.
REQ-025 START while BUSY SHALL be ignored, and BIN_IN changes after capture SHALL have no effect.
REQ-026 Watchdog: a 4-bit counter clears on entry to WAIT_HI and on entry to WAIT_LO, and increments each cycle spent in either state.
REQ-027 When the watchdog counter reaches 15, the block SHALL pulse ERR for 1 cycle, drive DEC_EN=0, and return to IDLE with no DONE.
REQ-028 DEC_EN SHALL be 0 in IDLE, CONVERT, NEXT and FIN.

Reset
REQ-029 On RST=1 the block SHALL enter IDLE and drive all outputs to 0; the BCD register, index and counters SHALL clear.
REQ-030 RST mid-operation SHALL abort immediately, with no DIGIT_DONE, DONE or ERR.
REQ-031 START on the first cycle after RST deasserts SHALL be accepted.

Configuration
REQ-032 Macro BCD_FEED_SKIP_ZEROS_EN SHALL be defined: the start index is the highest nonzero digit position, 0 if the value is 0; leading-zero digits are never sent; the ones digit is always sent.
REQ-033 Macro BCD_FEED_SKIP_ZEROS_EN SHALL be undefined: the start index is always 2, and all three digits are sent.

Verification
REQ-034 BIN_IN=157, START pulse -> DIGIT_DONE with (SEL, DIGIT_OUT) = (2,1), (1,5), (0,7), 6 cycles apart; DONE once.
REQ-035 BIN_IN=255 -> digits 2,5,5; BIN_IN=0 -> digits 0,0,0 with the macro undefined, a single digit 0 with SEL=0 with the macro defined.
REQ-036 BIN_IN=7 with the macro defined -> exactly one DIGIT_DONE, SEL=0, DIGIT_OUT=7; BUSY high for 8+6+1 cycles.
REQ-037 DEC_WAIT tied 0 -> ERR pulses 15 cycles after WAIT_HI entry; no DONE; next START accepted.
REQ-038 RST asserted in the 2nd digit's WAIT_LO -> all outputs 0 next cycle, no DONE; START with BIN_IN=42 then sends 0,4,2 (macro undefined).
REQ-039 START re-pulsed with a different BIN_IN while BUSY -> ignored; the original value's digits are sent unchanged.
